// File: rtl/amo_bank_arbiter.sv
// Round-robin arbiter funnelling N ports into one memory bank, with
// AMO busy cycles and a local LR/SC reservation monitor.
module amo_bank_arbiter #(
  parameter int NumPorts     = 4,
  parameter int AddrMemWidth = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumPorts-1:0]                       req_i,
  output logic [NumPorts-1:0]                       gnt_o,
  input  logic [NumPorts-1:0][AddrMemWidth-1:0]     add_i,
  input  logic [NumPorts-1:0][3:0]                  amo_i,
  input  logic [NumPorts-1:0]                       wen_i,
  input  logic [NumPorts-1:0][63:0]                 wdata_i,
  input  logic [NumPorts-1:0][7:0]                  be_i,
  output logic [63:0]                               rdata_o,
  output logic [NumPorts-1:0]                       rvalid_o,
  output logic                                      out_req_o,
  output logic [AddrMemWidth-1:0]                   out_add_o,
  output logic [3:0]                                out_amo_o,
  output logic                                      out_wen_o,
  output logic [63:0]                               out_wdata_o,
  output logic [7:0]                                out_be_o,
  input  logic                                      out_gnt_i,
  input  logic [63:0]                               out_rdata_i
);

  localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic {
    Idle,
    AmoBusy
  } state_e;

  localparam logic [3:0] AmoLr = 4'hB;
  localparam logic [3:0] AmoSc = 4'hC;

  state_e                  r_state;
  idx_t                    r_rr;
  logic                    r_resp_vld;
  idx_t                    r_resp_id;
  logic                    r_resp_lf;
  logic                    r_resp_hi;
  logic                    r_res_vld;
  idx_t                    r_res_owner;
  logic [AddrMemWidth-1:0] r_res_addr;

  logic                    w_found;
  idx_t                    w_win;
  logic [3:0]              w_amo;
  logic [AddrMemWidth-1:0] w_add;
  logic                    w_is_lr;
  logic                    w_is_sc;
  logic                    w_is_rmw;
  logic                    w_cand;
  logic                    w_res_ok;
  logic                    w_lfail;
  logic                    w_hs;
  logic                    w_res_kill;
  idx_t                    w_rr_nxt;

  // Doubled scan starting at r_rr gives the wrap-around priority order.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < 2 * NumPorts; i++) begin
      if (!w_found && i >= int'(r_rr)
          && req_i[i % NumPorts]) begin
        w_found = 1'b1;
        w_win   = idx_t'(i % NumPorts);
      end
    end
  end

  assign w_amo    = amo_i[w_win];
  assign w_add    = add_i[w_win];
  assign w_is_lr  = (w_amo == AmoLr);
  assign w_is_sc  = (w_amo == AmoSc);
  assign w_is_rmw = (w_amo >= 4'h1) && (w_amo <= 4'hA);

  assign w_cand   = rst_ni && (r_state == Idle) && w_found;
  assign w_res_ok = r_res_vld
                    && (r_res_owner == w_win)
                    && (r_res_addr == w_add);
  assign w_lfail  = w_cand && w_is_sc && !w_res_ok;

  assign out_req_o = w_cand && !w_lfail;
  assign w_hs      = out_req_o && out_gnt_i;

  assign w_res_kill = (wen_i[w_win] || w_is_rmw)
                      && (w_win != r_res_owner)
                      && (w_add == r_res_addr);

  assign w_rr_nxt = (w_win == idx_t'(NumPorts - 1))
                    ? '0 : w_win + idx_t'(1);

  // LR goes to the bank as an ordinary load.
  assign out_add_o   = w_add;
  assign out_amo_o   = w_is_lr ? 4'h0 : w_amo;
  assign out_wen_o   = wen_i[w_win] && !w_is_lr;
  assign out_wdata_o = wdata_i[w_win];
  assign out_be_o    = be_i[w_win];

  always_comb begin
    gnt_o = '0;
    if (w_hs || w_lfail) begin
      gnt_o[w_win] = 1'b1;
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (r_resp_vld) begin
      rvalid_o[r_resp_id] = 1'b1;
      if (r_resp_lf) begin
        rdata_o = r_resp_hi ? (64'h1 << 32) : 64'h1;
      end else begin
        rdata_o = out_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= Idle;
      r_rr        <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_id   <= '0;
      r_resp_lf   <= 1'b0;
      r_resp_hi   <= 1'b0;
      r_res_vld   <= 1'b0;
      r_res_owner <= '0;
      r_res_addr  <= '0;
    end else begin
      r_resp_vld <= w_hs || w_lfail;
      if (w_hs || w_lfail) begin
        r_rr      <= w_rr_nxt;
        r_resp_id <= w_win;
        r_resp_lf <= w_lfail;
        r_resp_hi <= be_i[w_win][4];
      end
      unique case (r_state)
        Idle: begin
          if (w_hs && (w_is_rmw || w_is_sc)) begin
            r_state <= AmoBusy;
          end
        end
        AmoBusy: begin
          r_state <= Idle;
        end
        default: begin
          r_state <= Idle;
        end
      endcase
      if (w_hs) begin
        unique case (1'b1)
          w_is_lr: begin
            r_res_vld   <= 1'b1;
            r_res_owner <= w_win;
            r_res_addr  <= w_add;
          end
          w_is_sc: begin
            r_res_vld <= 1'b0;
          end
          default: begin
            if (w_res_kill) begin
              r_res_vld <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Scoreboard bench for amo_bank_arbiter: a transaction-level model
// predicts grants and responses; a monitor pops and compares responses.
module tb_amo_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_i;
  logic [N-1:0]          gnt_o;
  logic [N-1:0][AW-1:0]  add_i;
  logic [N-1:0][3:0]     amo_i;
  logic [N-1:0]          wen_i;
  logic [N-1:0][63:0]    wdata_i;
  logic [N-1:0][7:0]     be_i;
  logic [63:0]           rdata_o;
  logic [N-1:0]          rvalid_o;
  logic                  out_req_o;
  logic [AW-1:0]         out_add_o;
  logic [3:0]            out_amo_o;
  logic                  out_wen_o;
  logic [63:0]           out_wdata_o;
  logic [7:0]            out_be_o;
  logic                  out_gnt_i;
  logic [63:0]           out_rdata_i;

  always #5 clk = ~clk;

  amo_bank_arbiter #(.NumPorts(N), .AddrMemWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .amo_i(amo_i),
    .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .out_req_o(out_req_o),
    .out_add_o(out_add_o), .out_amo_o(out_amo_o),
    .out_wen_o(out_wen_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_gnt_i(out_gnt_i),
    .out_rdata_i(out_rdata_i)
  );

  typedef struct {
    int          port;
    logic [63:0] data;
    int          due;
  } resp_t;

  resp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pending transaction per port (held until granted).
  logic          pend [N];
  logic [3:0]    t_amo[N];
  logic          t_wen[N];
  logic [AW-1:0] t_add[N];
  logic [7:0]    t_be [N];
  logic [63:0]   t_wd [N];

  // Reference model state.
  int            m_rr;
  bit            m_busy;
  bit            m_rv;
  int            m_ro;
  logic [AW-1:0] m_ra;

  function automatic logic [63:0] bank_data(int c);
    logic [31:0] a;
    a = 32'(c);
    return {a * 32'h9E3779B9, ~a};
  endfunction

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_txn(int p, logic [3:0] a, logic w,
                         logic [AW-1:0] ad, logic [7:0] b);
    pend[p]  = 1'b1;
    t_amo[p] = a;
    t_wen[p] = w;
    t_add[p] = ad;
    t_be[p]  = b;
    t_wd[p]  = {$urandom, $urandom};
  endtask

  task automatic new_txn(int p);
    int r;
    logic [3:0] a;
    logic w;
    r = $urandom_range(0, 9);
    if (r < 4) a = 4'h0;
    else if (r < 6) a = 4'($urandom_range(1, 10));
    else if (r < 8) a = 4'hB;
    else a = 4'hC;
    if (a == 4'h0) w = 1'($urandom_range(0, 1));
    else if (a == 4'hB) w = 1'b0;
    else w = 1'b1;
    set_txn(p, a, w, AW'(32'h40 * $urandom_range(1, 3)),
            8'($urandom));
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_i[p]   = pend[p];
      add_i[p]   = t_add[p];
      amo_i[p]   = t_amo[p];
      wen_i[p]   = t_wen[p];
      wdata_i[p] = t_wd[p];
      be_i[p]    = t_be[p];
    end
  endtask

  // Predict this cycle's arbitration outcome from the port queue.
  task automatic model_eval(bit g);
    logic [N-1:0] eg;
    bit er;
    bit served;
    bit ok;
    int w;
    eg = '0;
    er = 1'b0;
    served = 1'b0;
    w = -1;
    if (m_busy) begin
      m_busy = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w < 0 && pend[(m_rr + i) % N]) w = (m_rr + i) % N;
      end
      if (w >= 0) begin
        ok = m_rv && m_ro == w && m_ra == t_add[w];
        if (t_amo[w] == 4'hC && !ok) begin
          eg[w] = 1'b1;
          served = 1'b1;
          sb.push_back('{w, t_be[w][4] ? (64'h1 << 32) : 64'h1,
                         cyc + 1});
        end else begin
          er = 1'b1;
          check("out_add", 64'(out_add_o), 64'(t_add[w]));
          check("out_amo", 64'(out_amo_o),
                64'(t_amo[w] == 4'hB ? 4'h0 : t_amo[w]));
          check("out_wen", 64'(out_wen_o), 64'(t_wen[w]));
          check("out_wdata", out_wdata_o, t_wd[w]);
          check("out_be", 64'(out_be_o), 64'(t_be[w]));
          if (g) begin
            eg[w] = 1'b1;
            served = 1'b1;
            sb.push_back('{w, bank_data(cyc + 1), cyc + 1});
            if (t_amo[w] == 4'hB) begin
              m_rv = 1'b1;
              m_ro = w;
              m_ra = t_add[w];
            end else if (t_amo[w] == 4'hC) begin
              m_rv = 1'b0;
            end else if ((t_wen[w] || t_amo[w] != 4'h0)
                         && w != m_ro && t_add[w] == m_ra) begin
              m_rv = 1'b0;
            end
            if (t_amo[w] != 4'h0 && t_amo[w] != 4'hB) m_busy = 1'b1;
          end
        end
        if (served) begin
          m_rr = (w + 1) % N;
          pend[w] = 1'b0;
        end
      end
    end
    check("gnt", 64'(gnt_o), 64'(eg));
    check("out_req", 64'(out_req_o), 64'(er));
  endtask

  task automatic do_cycle(bit g);
    drive();
    out_gnt_i   = g;
    out_rdata_i = bank_data(cyc);
    #1;
    model_eval(g);
  endtask

  task automatic step(bit g);
    @(negedge clk);
    do_cycle(g);
  endtask

  task automatic serve(int p);
    int n;
    n = 0;
    while (pend[p] && n < 30) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (pend[p]) begin
      failures++;
      $display("FAIL serve_timeout port=%0d actual=pending required=granted", p);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_rr = 0;
    m_busy = 1'b0;
    m_rv = 1'b0;
    m_ro = 0;
    m_ra = '0;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_gnt"}, 64'(gnt_o), 64'h0);
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'h0);
    check({tag, "_rdata"}, rdata_o, 64'h0);
    check({tag, "_out_req"}, 64'(out_req_o), 64'h0);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    #2;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL resp_missing port=%0d actual=none required=cycle%0d",
               e.port, e.due);
    end
    if (rvalid_o != '0) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 64'(rvalid_o), 64'h0);
      end else begin
        e = sb.pop_front();
        check("rvalid", 64'(rvalid_o), 64'(1) << e.port);
        check("rdata", rdata_o, e.data);
        check("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("rdata_idle", rdata_o, 64'h0);
    end
  end

  initial begin
    int n;
    bit any;
    for (int p = 0; p < N; p++) set_txn(p, 4'h0, 1'b0, '0, '0);
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    model_reset();
    rst_n = 1'b0;
    out_gnt_i = 1'b1;
    out_rdata_i = '0;
    drive();
    req_i = '1;
    #1;
    check_quiet("reset");
    @(negedge clk);
    #1;
    check_quiet("reset2");
    req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b1);

    // All ports load back to back.
    for (int p = 0; p < N; p++) set_txn(p, 4'h0, 1'b0, 32'h100, 8'hFF);
    for (int i = 0; i < N; i++) step(1'b1);

    // AMO on port 1 blocks one cycle before port 2 load.
    set_txn(1, 4'h2, 1'b1, 32'h80, 8'hFF);
    set_txn(2, 4'h0, 1'b0, 32'h80, 8'hFF);
    for (int i = 0; i < 3; i++) step(1'b1);

    // Bank stalls with port 3 waiting.
    set_txn(3, 4'h0, 1'b0, 32'hC0, 8'h0F);
    for (int i = 0; i < 3; i++) step(1'b0);
    step(1'b1);

    // LR/SC pair succeeds.
    set_txn(0, 4'hB, 1'b0, 32'h40, 8'hFF);
    serve(0);
    set_txn(0, 4'hC, 1'b1, 32'h40, 8'h0F);
    serve(0);

    // Intervening store from another port kills the reservation.
    set_txn(0, 4'hB, 1'b0, 32'h40, 8'hFF);
    serve(0);
    set_txn(2, 4'h0, 1'b1, 32'h40, 8'hFF);
    serve(2);
    set_txn(0, 4'hC, 1'b1, 32'h40, 8'h0F);
    serve(0);
    set_txn(1, 4'hC, 1'b1, 32'h40, 8'hF0);
    serve(1);
    step(1'b1);
    step(1'b1);

    // Reset in the middle of an AMO busy cycle.
    set_txn(1, 4'h3, 1'b1, 32'h80, 8'hFF);
    serve(1);
    @(negedge clk);
    rst_n = 1'b0;
    set_txn(0, 4'h0, 1'b0, 32'h40, 8'hFF);
    set_txn(2, 4'h0, 1'b0, 32'h80, 8'hFF);
    drive();
    out_gnt_i = 1'b1;
    #1;
    check_quiet("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b1);
    step(1'b1);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 35) new_txn(p);
      end
      step($urandom_range(0, 3) != 0);
    end

    n = 0;
    any = 1'b1;
    while (any && n < 200) begin
      step(1'b1);
      any = 1'b0;
      for (int p = 0; p < N; p++) any |= pend[p];
      n++;
    end
    checks++;
    if (any) begin
      failures++;
      $display("FAIL drain actual=pending required=idle");
    end
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
